kinpira_axi_lite_regs: RTL

//  AXI4-Lite slave register file; responder to the cdn_axi4_lite_master BFM in the bfm_design bench.

---
 rtl/kinpira_axi_pkg.sv | 27 ++
 rtl/kinpira_axi_lite_wstrb_merge.sv | 21 ++
 rtl/kinpira_axi_lite_regs.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/kinpira_axi_pkg.sv
// Shared constants for the kinpira AXI4-Lite register block: response codes, word-address shift, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package kinpira_axi_pkg;

    localparam int ADDR_LSB = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Response code for a decoded access: in-range words answer OKAY, holes answer SLVERR.
    function automatic logic [1:0] decode_resp(input logic in_range);
        return in_range ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/kinpira_axi_lite_wstrb_merge.sv
// Byte-lane merge of a write word into the current register value under WSTRB.
// Latency: purely combinational.
// Backpressure: none.
module kinpira_axi_lite_wstrb_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] new_word
);

    // Each enabled byte lane takes the write data, the others keep the old contents.
    always_comb begin
        new_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                new_word[8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/kinpira_axi_lite_regs.sv
// AXI4-Lite slave register file with one read-only status word and per-register write pulses.
// Latency: BVALID one cycle after the later of AW/W handshakes; RVALID one cycle after AR handshake.
// Backpressure: one write and one read outstanding; AW/W/AR ready drop until B/R are accepted.
module kinpira_axi_lite_regs
    import kinpira_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 8,
    parameter int STATUS_IDX         = 7
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_q,
    output logic [NUM_REGS-1:0]               reg_we,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in
);

    localparam int              IW    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [IW:0]     NREGS = (IW+1)'(NUM_REGS);
    localparam logic [IW-1:0]   SIDX  = IW'(STATUS_IDX);

    logic [31:0]   regs [NUM_REGS];

    wr_state_e     w_state, w_next;
    rd_state_e     r_state, r_next;

    logic          aw_held, w_held;
    logic [IW-1:0] aw_idx_q;
    logic [31:0]   w_dat_q;
    logic [3:0]    w_strb_q;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] w_idx, r_idx;
    logic [31:0]   w_dat;
    logic [3:0]    w_strb;
    logic          w_in_range, r_in_range;
    logic [31:0]   old_word, merged_word, rd_word;

    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic [NUM_REGS-1:0] we_q;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic unused_bits;
    assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Ready is held low while reset is asserted so the master never sees a handshake then.
    assign S_AXI_AWREADY = ARESETN && (w_state == W_IDLE) && !aw_held;
    assign S_AXI_WREADY  = ARESETN && (w_state == W_IDLE) && !w_held;
    assign S_AXI_ARREADY = ARESETN && (r_state == R_IDLE);

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // The second of AW/W to arrive is used straight off the bus, so commit lands on its handshake edge.
    assign w_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: IW];
    assign w_dat  = w_held  ? w_dat_q  : S_AXI_WDATA;
    assign w_strb = w_held  ? w_strb_q : S_AXI_WSTRB;
    assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

    assign r_idx      = S_AXI_ARADDR[ADDR_LSB +: IW];
    assign w_in_range = {1'b0, w_idx} < NREGS;
    assign r_in_range = {1'b0, r_idx} < NREGS;

    // Current contents of the register targeted by the write; zero for holes.
    always_comb begin
        old_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IW'(i)) begin
                old_word = regs[i];
            end
        end
    end

    kinpira_axi_lite_wstrb_merge u_merge (
        .old_word (old_word),
        .wdata    (w_dat),
        .wstrb    (w_strb),
        .new_word (merged_word)
    );

    // Read mux: storage for normal words, live status for the status slot, zero for holes.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IW'(i)) begin
                rd_word = regs[i];
            end
        end
        if (r_idx == SIDX) begin
            rd_word = status_in;
        end
    end

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state: idle until a full AW+W pair commits, then wait for BREADY.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (commit)       w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Holding registers, register array update, write pulses and write response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_dat_q  <= '0;
            w_strb_q <= '0;
            bresp_q  <= RESP_OKAY;
            we_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            we_q <= '0;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp_q <= decode_resp(w_in_range);
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_in_range && (w_idx == IW'(i)) && (i != STATUS_IDX)) begin
                        regs[i] <= merged_word;
                        we_q[i] <= 1'b1;
                    end
                end
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_LSB +: IW];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_dat_q  <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state: idle until AR handshake, then hold data until RREADY.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)        r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Capture read data and response at the AR handshake; they stay put while RVALID is up.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word;
            rresp_q <= decode_resp(r_in_range);
        end
    end

    assign S_AXI_BVALID = (w_state == W_RESP);
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = (r_state == R_DATA);
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign reg_we       = we_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[32*g +: 32] = regs[g];
    end

endmodule
